// File: rtl/yutorina_ex_stage_pkg.sv
// Shared encodings for the Yutorina execute stage: ALU opcodes, memory/control/exception
// codes, active-low enable levels and the divider state type.
package yutorina_ex_stage_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;
  localparam int REG_W  = 5;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [REG_W-1:0] GPR_ZERO = 5'd0;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SHRL = 4'd6;
  localparam logic [3:0] ALU_SHLL = 4'd7;
  localparam logic [3:0] ALU_SHRA = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIVU = 4'd10;
  localparam logic [3:0] ALU_REMU = 4'd11;

  localparam logic [3:0] MEM_NONE  = 4'd0;
  localparam logic [2:0] CTRL_NONE = 3'd0;

  localparam logic [2:0] EXP_NONE     = 3'd0;
  localparam logic [2:0] EXP_OVERFLOW = 3'd3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/yutorina_ex_stage_if.sv
// ID/EX input bundle, EX/MEM output bundle, forwarding pair and divider debug state.
interface yutorina_ex_stage_if;
  import yutorina_ex_stage_pkg::*;

  logic              id_en_;
  logic [ADDR_W-1:0] id_pc;
  logic [3:0]        id_alu_op;
  logic [WORD_W-1:0] id_alu_lhs;
  logic [WORD_W-1:0] id_alu_rhs;
  logic [REG_W-1:0]  id_w_addr;
  logic [WORD_W-1:0] id_w_data;
  logic              id_gpr_we_;
  logic [2:0]        id_exp_code;
  logic [3:0]        id_mem_op;
  logic [2:0]        id_ctrl_op;

  // Handshake: an id_* bundle is consumed at an edge where ex_busy=0 and stall=0.
  // While ex_busy=1 the driver must hold every id_* field stable.
  logic              ex_busy;
  logic [REG_W-1:0]  ex_fwd_addr;
  logic [WORD_W-1:0] ex_fwd_out;

  logic              ex_en_;
  logic [ADDR_W-1:0] ex_pc;
  logic [REG_W-1:0]  ex_w_addr;
  logic              ex_gpr_we_;
  logic [3:0]        ex_mem_op;
  logic [2:0]        ex_ctrl_op;
  logic [2:0]        ex_exp_code;
  logic [WORD_W-1:0] ex_out;
  logic [WORD_W-1:0] ex_mem_wdata;

  div_state_e        div_state;

  modport master (
    output id_en_, id_pc, id_alu_op, id_alu_lhs, id_alu_rhs, id_w_addr, id_w_data,
           id_gpr_we_, id_exp_code, id_mem_op, id_ctrl_op,
    input  ex_busy, ex_fwd_addr, ex_fwd_out, ex_en_, ex_pc, ex_w_addr, ex_gpr_we_,
           ex_mem_op, ex_ctrl_op, ex_exp_code, ex_out, ex_mem_wdata, div_state
  );

  modport slave (
    input  id_en_, id_pc, id_alu_op, id_alu_lhs, id_alu_rhs, id_w_addr, id_w_data,
           id_gpr_we_, id_exp_code, id_mem_op, id_ctrl_op,
    output ex_busy, ex_fwd_addr, ex_fwd_out, ex_en_, ex_pc, ex_w_addr, ex_gpr_we_,
           ex_mem_op, ex_ctrl_op, ex_exp_code, ex_out, ex_mem_wdata, div_state
  );

endinterface

// File: rtl/yutorina_ex_stage_divider.sv
// Iterative restoring unsigned divider, one quotient bit per non-stalled edge.
// The first step is taken on the start edge so DIV_CYCLES steps fit in DIV_CYCLES busy cycles.
module yutorina_ex_stage_divider
  import yutorina_ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIV_CYCLES-1:0] dividend,
  input  logic [DIV_CYCLES-1:0] divisor,
  output logic                  busy,
  output logic [DIV_CYCLES-1:0] quotient,
  output logic [DIV_CYCLES-1:0] remainder,
  output div_state_e            state
);

  localparam int W     = DIV_CYCLES;
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;

  logic [W-1:0]     step_rem_in, step_quo_in, step_dsr;
  logic [W:0]       trial, trial_diff;
  logic             fits;
  logic [W-1:0]     step_rem, step_quo;

  // In IDLE the step consumes the incoming operands directly.
  always_comb begin
    step_rem_in = (state_q == DIV_IDLE) ? '0       : rem_q;
    step_quo_in = (state_q == DIV_IDLE) ? dividend : quo_q;
    step_dsr    = (state_q == DIV_IDLE) ? divisor  : dsr_q;
    trial       = {step_rem_in, step_quo_in[W-1]};
    trial_diff  = trial - {1'b0, step_dsr};
    fits        = (trial >= {1'b0, step_dsr});
    step_rem    = fits ? trial_diff[W-1:0] : trial[W-1:0];
    step_quo    = {step_quo_in[W-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    busy    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        busy = start;
        if (start && !abort && !stall) begin
          state_d = DIV_RUN;
          cnt_d   = CNT_W'(1);
          rem_d   = step_rem;
          quo_d   = step_quo;
          dsr_d   = divisor;
        end
      end
      DIV_RUN: begin
        busy = 1'b1;
        if (!stall) begin
          if (abort) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
          end else begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
              state_d = DIV_DONE;
              cnt_d   = '0;
            end
          end
        end
      end
      DIV_DONE: begin
        if (!stall) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign state     = state_q;

endmodule

// File: rtl/yutorina_ex_stage.sv
// Yutorina execute stage: inline ALU, iterative divider, EX/MEM register and
// combinational forwarding back to decode.
module yutorina_ex_stage
  import yutorina_ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  yutorina_ex_stage_if.slave bus
);

  logic              div_start, div_busy;
  logic [WORD_W-1:0] div_quo, div_rem;
  div_state_e        div_state;

  logic [WORD_W-1:0] sum, diff, alu_out;
  logic              ovf;

  logic              en_q, gpr_we_q;
  logic [ADDR_W-1:0] pc_q;
  logic [REG_W-1:0]  w_addr_q;
  logic [3:0]        mem_op_q;
  logic [2:0]        ctrl_op_q, exp_code_q;
  logic [WORD_W-1:0] out_q, mem_wdata_q;

  assign div_start = (bus.id_en_ == ENABLE_) && is_div_op(bus.id_alu_op)
                     && (bus.id_alu_rhs != '0);

  yutorina_ex_stage_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .start     (div_start),
    .abort     (flush),
    .dividend  (bus.id_alu_lhs),
    .divisor   (bus.id_alu_rhs),
    .busy      (div_busy),
    .quotient  (div_quo),
    .remainder (div_rem),
    .state     (div_state)
  );

  always_comb begin
    sum     = bus.id_alu_lhs + bus.id_alu_rhs;
    diff    = bus.id_alu_lhs - bus.id_alu_rhs;
    ovf     = 1'b0;
    alu_out = '0;
    case (bus.id_alu_op)
      ALU_ADD: begin
        alu_out = sum;
        ovf     = (bus.id_alu_lhs[31] == bus.id_alu_rhs[31]) && (sum[31] != bus.id_alu_lhs[31]);
      end
      ALU_SUB: begin
        alu_out = diff;
        ovf     = (bus.id_alu_lhs[31] != bus.id_alu_rhs[31]) && (diff[31] != bus.id_alu_lhs[31]);
      end
      ALU_AND:  alu_out = bus.id_alu_lhs & bus.id_alu_rhs;
      ALU_OR:   alu_out = bus.id_alu_lhs | bus.id_alu_rhs;
      ALU_XOR:  alu_out = bus.id_alu_lhs ^ bus.id_alu_rhs;
      ALU_SHRL: alu_out = bus.id_alu_lhs >> bus.id_alu_rhs[4:0];
      ALU_SHLL: alu_out = bus.id_alu_lhs << bus.id_alu_rhs[4:0];
      ALU_SHRA: alu_out = $signed(bus.id_alu_lhs) >>> bus.id_alu_rhs[4:0];
      ALU_MUL:  alu_out = bus.id_alu_lhs * bus.id_alu_rhs;
      // Divide by zero never enters the divider and resolves here in one cycle.
      ALU_DIVU: alu_out = (bus.id_alu_rhs == '0) ? '1 : div_quo;
      ALU_REMU: alu_out = (bus.id_alu_rhs == '0) ? bus.id_alu_lhs : div_rem;
      default:  alu_out = '0;
    endcase
    if (bus.id_mem_op != MEM_NONE) alu_out = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= DISABLE_;
      pc_q        <= '0;
      out_q       <= '0;
      mem_wdata_q <= '0;
      w_addr_q    <= GPR_ZERO;
      gpr_we_q    <= DISABLE_;
      mem_op_q    <= MEM_NONE;
      ctrl_op_q   <= CTRL_NONE;
      exp_code_q  <= EXP_NONE;
    end else if (!stall) begin
      en_q        <= div_busy ? DISABLE_ : bus.id_en_;
      pc_q        <= bus.id_pc;
      out_q       <= alu_out;
      mem_wdata_q <= bus.id_w_data;
      if (flush || div_busy) begin
        w_addr_q   <= GPR_ZERO;
        gpr_we_q   <= DISABLE_;
        mem_op_q   <= MEM_NONE;
        ctrl_op_q  <= CTRL_NONE;
        exp_code_q <= EXP_NONE;
      end else begin
        w_addr_q  <= bus.id_w_addr;
        mem_op_q  <= bus.id_mem_op;
        ctrl_op_q <= bus.id_ctrl_op;
        // An exception already raised upstream wins over an ALU overflow.
        if (bus.id_exp_code != EXP_NONE) begin
          exp_code_q <= bus.id_exp_code;
          gpr_we_q   <= bus.id_gpr_we_;
        end else if (ovf) begin
          exp_code_q <= EXP_OVERFLOW;
          gpr_we_q   <= DISABLE_;
        end else begin
          exp_code_q <= EXP_NONE;
          gpr_we_q   <= bus.id_gpr_we_;
        end
      end
    end
  end

  assign bus.ex_busy      = div_busy;
  assign bus.ex_en_       = en_q;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_w_addr    = w_addr_q;
  assign bus.ex_gpr_we_   = gpr_we_q;
  assign bus.ex_mem_op    = mem_op_q;
  assign bus.ex_ctrl_op   = ctrl_op_q;
  assign bus.ex_exp_code  = exp_code_q;
  assign bus.ex_out       = out_q;
  assign bus.ex_mem_wdata = mem_wdata_q;
  assign bus.ex_fwd_out   = out_q;
  assign bus.ex_fwd_addr  = (gpr_we_q == ENABLE_) ? w_addr_q : GPR_ZERO;
  assign bus.div_state    = div_state;

endmodule
